// File: rtl/regfile_demux.sv
// Register file with a one-hot write demultiplexer, two combinational read
// ports and write-first bypass from the WB write port to the ID read ports.

module regfile_demux_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

module regfile_demux #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WE,
    input  logic [ADDR_BITS-1:0]    WADDR,
    input  logic [WIDTH-1:0]        WDATA,
    input  logic [ADDR_BITS-1:0]    RADDR_A,
    input  logic [ADDR_BITS-1:0]    RADDR_B,
    output logic [WIDTH-1:0]        RDATA_A,
    output logic [WIDTH-1:0]        RDATA_B,
    output logic [2**ADDR_BITS-1:0] WR_ONEHOT
);
    localparam int NREGS = 2**ADDR_BITS;

    logic [NREGS-1:0]            en;
    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic                        wr_live;
    logic                        byp_a;
    logic                        byp_b;

    // With ZERO_REG set, slot 0 has no storage and its enable is tied off.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign en[i]   = 1'b0;
            assign regs[i] = '0;
        end else begin : g_flop
            assign en[i] = WE && (WADDR == ADDR_BITS'(i));
            regfile_demux_reg #(.WIDTH(WIDTH)) u_reg (
                .clk (CLK),
                .rst (RST),
                .en  (en[i]),
                .d   (WDATA),
                .q   (regs[i])
            );
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) WR_ONEHOT <= '0;
        else     WR_ONEHOT <= en;
    end

    // WE gates every bypass term, so X on WADDR/WDATA is harmless while idle.
    assign wr_live = WE && ((ZERO_REG == 0) || (WADDR != '0));
    assign byp_a   = wr_live && (WADDR == RADDR_A);
    assign byp_b   = wr_live && (WADDR == RADDR_B);

    always_comb begin
        RDATA_A = regs[RADDR_A];
        if (byp_a) RDATA_A = WDATA;
        if (RST)   RDATA_A = '0;
    end

    always_comb begin
        RDATA_B = regs[RADDR_B];
        if (byp_b) RDATA_B = WDATA;
        if (RST)   RDATA_B = '0;
    end
endmodule
